vischain_collect: RTL and testbench

- Sink at the tail end of a correlator visibility chain.
- The chain shifts out one WIDTH-bit word per valid_i strobe, with no backpressure. Each unit contributes its real word, then its imaginary word; units are ordered 0..LENGTH-1 and the order repeats every frame.
- The block re-pairs the words and tags each pair with its unit index and end-of-frame. Pairs are buffered in a small FIFO and presented on a valid/ready stream to the readout/accumulator logic.
- Overruns are detected and reported, never stalled.

---
 rtl/vischain_collect.sv | 163 ++++++++++++++++
 tb/tb_vischain_collect.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vischain_collect.sv
// vischain_collect: tail sink of a correlator visibility chain.
// Collects the alternating re/im words into pairs and tags each pair with
// its unit index and end-of-frame. Pairs are queued in a small
// first-word-fall-through FIFO that feeds a valid/ready stream. When the
// FIFO is full a pair is dropped and the sticky overflow flag is raised;
// the chain is never stalled.
module vischain_collect #(
    parameter int LENGTH = 3,
    parameter int WIDTH  = 7,
    parameter int DEPTH  = 4,
    parameter int IBITS  = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       valid_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [2*WIDTH-1:0]         m_tdata,
    output logic [IBITS-1:0]           m_tuser,
    output logic                       m_tlast,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    // FIFO entry layout: {tlast, tuser, im, re}
    localparam int EW = 2 * WIDTH + IBITS + 1;

    typedef enum logic {
        PH_RE = 1'b0,
        PH_IM = 1'b1
    } phase_t;

    phase_t             phase_q, phase_d;
    logic [IBITS-1:0]   index_q, index_d;
    logic [WIDTH-1:0]   re_hold_q, re_hold_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               overflow_q, overflow_d;
    logic [EW-1:0]      mem_q [DEPTH];

    logic               pair_done;
    logic               pop;
    logic               full;
    logic               push;
    logic               is_last;
    logic [EW-1:0]      entry_d;
    logic [EW-1:0]      head;

    // Word-phase FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= PH_RE;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Word-phase FSM next state: re and im alternate, idle cycles hold.
    always_comb begin
        phase_d   = phase_q;
        pair_done = 1'b0;
        if (valid_i) begin
            case (phase_q)
                PH_RE: phase_d = PH_IM;
                PH_IM: begin
                    phase_d   = PH_RE;
                    pair_done = 1'b1;
                end
                default: phase_d = PH_RE;
            endcase
        end
    end

    // Pair assembly, index counter, FIFO bookkeeping and overflow detection.
    always_comb begin
        re_hold_d  = re_hold_q;
        index_d    = index_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        is_last = (index_q == IBITS'(LENGTH - 1));
        entry_d = {is_last, index_q, data_i, re_hold_q};

        pop  = m_tvalid && m_tready;
        full = (level_q == LW'(DEPTH));
        // A full FIFO still accepts a pair when the head leaves this cycle.
        push = pair_done && (!full || pop);

        if (valid_i && (phase_q == PH_RE)) begin
            re_hold_d = data_i;
        end

        // The index advances on every completed pair, dropped or not.
        if (pair_done) begin
            index_d = is_last ? '0 : index_q + IBITS'(1);
        end

        if (pair_done && !push) begin
            overflow_d = 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state: index, pointers, occupancy and sticky overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            index_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            index_q    <= index_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Data storage is left unreset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        re_hold_q <= re_hold_d;
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= entry_d;
        end
    end

    // Head of the FIFO drives the stream; zeros whenever nothing is queued.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        m_tvalid   = (level_q != '0);
        m_tdata    = '0;
        m_tuser    = '0;
        m_tlast    = 1'b0;
        if (m_tvalid) begin
            m_tdata = head[2*WIDTH-1:0];
            m_tuser = head[2*WIDTH +: IBITS];
            m_tlast = head[EW-1];
        end
        level_o    = level_q;
        overflow_o = overflow_q;
    end

endmodule

// File: tb/tb_vischain_collect.sv
// Bench for vischain_collect: directed scenarios followed by randomized
// traffic, all compared every cycle against a queue-based reference model.
module tb_vischain_collect;

    localparam int LENGTH = 3;
    localparam int WIDTH  = 7;
    localparam int DEPTH  = 4;
    localparam int IBITS  = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    logic                    clock;
    logic                    reset;
    logic                    valid_i;
    logic [WIDTH-1:0]        data_i;
    logic                    m_tvalid;
    logic                    m_tready;
    logic [2*WIDTH-1:0]      m_tdata;
    logic [IBITS-1:0]        m_tuser;
    logic                    m_tlast;
    logic [$clog2(DEPTH):0]  level_o;
    logic                    overflow_o;

    vischain_collect #(
        .LENGTH (LENGTH),
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tuser    (m_tuser),
        .m_tlast    (m_tlast),
        .level_o    (level_o),
        .overflow_o (overflow_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int data;
        int user;
        bit last;
    } pair_t;

    // Reference model state
    pair_t q[$];
    bit    have_re;
    int    re_word;
    int    pairs_seen;
    bit    ovf;
    bit    clean;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit v, input int d, input bit rdy);
        pair_t e;
        bit    pop;
        bit    room;
        bit    have_pair;
        if (rst) begin
            q.delete();
            have_re    = 0;
            pairs_seen = 0;
            ovf        = 0;
            clean      = 1;
            return;
        end
        have_pair = 0;
        pop  = rdy && (q.size() != 0);
        room = (q.size() < DEPTH) || pop;
        if (v) begin
            if (!have_re) begin
                re_word = d;
                have_re = 1;
            end else begin
                have_re   = 0;
                e.data    = (d << WIDTH) | re_word;
                e.user    = pairs_seen % LENGTH;
                e.last    = (e.user == LENGTH - 1);
                pairs_seen++;
                have_pair = 1;
            end
        end
        if (pop) void'(q.pop_front());
        if (have_pair) begin
            if (room) begin
                q.push_back(e);
                clean = 0;
            end else begin
                ovf = 1;
            end
        end
    endtask

    task automatic compare_outputs();
        check("tvalid", 32'(m_tvalid), 32'(q.size() != 0));
        check("level", 32'(level_o), 32'(q.size()));
        check("overflow", 32'(overflow_o), 32'(ovf));
        if (q.size() != 0) begin
            check("tdata", 32'(m_tdata), 32'(q[0].data));
            check("tuser", 32'(m_tuser), 32'(q[0].user));
            check("tlast", 32'(m_tlast), 32'(q[0].last));
        end else if (clean) begin
            check("tdata_rst", 32'(m_tdata), 32'd0);
            check("tuser_rst", 32'(m_tuser), 32'd0);
            check("tlast_rst", 32'(m_tlast), 32'd0);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then check.
    task automatic cycle(input bit rst, input bit v, input int d, input bit rdy);
        reset    = rst;
        valid_i  = v;
        data_i   = WIDTH'(d);
        m_tready = rdy;
        @(posedge clock);
        model_step(rst, v, d, rdy);
        #1;
        compare_outputs();
    endtask

    task automatic send_pair(input int re, input int im, input bit rdy);
        cycle(0, 1, re, rdy);
        cycle(0, 1, im, rdy);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        valid_i  = 1'b0;
        data_i   = '0;
        m_tready = 1'b0;
        have_re  = 0;
        re_word  = 0;
        pairs_seen = 0;
        ovf      = 0;
        clean    = 1;

        // Reset state
        cycle(1, 0, 0, 0);
        cycle(1, 1, 5, 1);
        cycle(0, 0, 0, 0);

        // Basic frame, consecutive words, consumer always ready
        send_pair(1, 2, 1);
        check("basic_p0", 32'(m_tdata), 32'h0101);
        send_pair(3, 4, 1);
        check("basic_p1", 32'(m_tdata), 32'h0203);
        send_pair(5, 6, 1);
        check("basic_p2", 32'(m_tdata), 32'h0305);
        check("basic_last", 32'(m_tlast), 32'd1);
        cycle(0, 0, 0, 1);

        // Gapped input: idle cycles between re and im of unit 1
        send_pair(1, 2, 1);
        cycle(0, 1, 3, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 1);
            check("gap_idle", 32'(m_tvalid), 32'd0);
        end
        cycle(0, 1, 4, 1);
        check("gap_p1", 32'(m_tdata), 32'h0203);
        send_pair(5, 6, 1);
        cycle(0, 0, 0, 1);

        // Backpressure and overflow
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) send_pair(2 * i + 1, 2 * i + 2, 0);
        check("ovf_level", 32'(level_o), 32'd4);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
        check("ovf_drained", 32'(level_o), 32'd0);
        send_pair(7, 8, 0);
        check("ovf_next_idx", 32'(m_tuser), 32'd2);

        // Full with a simultaneous pop
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) send_pair(i + 16, i + 32, 0);
        cycle(0, 1, 48, 0);
        cycle(0, 1, 64, 1);
        check("fullpop_level", 32'(level_o), 32'd4);
        check("fullpop_ovf", 32'(overflow_o), 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);

        // Output stability under backpressure
        cycle(1, 0, 0, 0);
        send_pair(8'h0A, 8'h15, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, i + 40, 0);
            check("stable_data", 32'(m_tdata), 32'((8'h15 << WIDTH) | 8'h0A));
            check("stable_user", 32'(m_tuser), 32'd0);
        end

        // Reset mid-frame
        cycle(1, 0, 0, 0);
        send_pair(1, 2, 1);
        cycle(0, 1, 3, 1);
        cycle(1, 0, 0, 0);
        check("midrst_level", 32'(level_o), 32'd0);
        check("midrst_ovf", 32'(overflow_o), 32'd0);
        send_pair(8'h11, 8'h22, 0);
        check("midrst_data", 32'(m_tdata), 32'h1111);
        check("midrst_user", 32'(m_tuser), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 399) == 0),
                  ($urandom_range(0, 99) < 65),
                  int'($urandom_range(0, (1 << WIDTH) - 1)),
                  ($urandom_range(0, 99) < 45));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
